// File: rtl/pwm_bridge_burst.sv
// Multi-channel complementary pulse-pair burst generator: NCH independent engines share one
// configuration bus and each drive an a/b pair with on-times, dead time, burst count and idle level.
module pwm_bridge_burst #(
  parameter int CW  = 32,
  parameter int NCH = 4
) (
  input  logic           io_clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] start_mask,
  input  logic [NCH-1:0] stop_mask,
  input  logic [CW-1:0]  a_len,
  input  logic [CW-1:0]  b_len,
  input  logic [CW-1:0]  dead_len,
  input  logic [CW-1:0]  pulse_cnt,
  input  logic           idle_level,
  output logic [NCH-1:0] pulse_a,
  output logic [NCH-1:0] pulse_b,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done,
  output logic           cfg_err
);

  typedef enum logic [2:0] {IDLE, A_ON, DEAD1, B_ON, DEAD2} state_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  logic           cfg_ok;
  logic [NCH-1:0] reject;
  logic           cfg_err_reg;

  assign cfg_ok = (a_len != '0) && (b_len != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_eng
      state_t        state_reg, state_next;
      logic [CW-1:0] cnt_reg, cnt_next;
      logic [CW-1:0] period_reg, period_next, period_inc;
      logic [CW-1:0] a_reg, a_next, b_reg, b_next;
      logic [CW-1:0] d_reg, d_next, n_reg, n_next;
      logic          lvl_reg, lvl_next, stop_reg, stop_next;
      logic          pa_reg, pa_next, pb_reg, pb_next;
      logic          busy_reg, done_reg, done_next;
      logic          reject_bit, period_end, out_lvl;

      always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        period_next = period_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        d_next      = d_reg;
        n_next      = n_reg;
        lvl_next    = lvl_reg;
        stop_next   = stop_reg;
        done_next   = 1'b0;
        reject_bit  = 1'b0;
        period_end  = 1'b0;
        period_inc  = period_reg + ONE;

        if ((state_reg != IDLE) && stop_mask[gi]) stop_next = 1'b1;

        // Each phase counter is loaded with its length and exits on the cycle it reads 1.
        case (state_reg)
          IDLE: begin
            if (start_mask[gi]) begin
              if (cfg_ok) begin
                state_next  = A_ON;
                cnt_next    = a_len;
                period_next = '0;
                a_next      = a_len;
                b_next      = b_len;
                d_next      = dead_len;
                n_next      = pulse_cnt;
                lvl_next    = idle_level;
                stop_next   = 1'b0;
              end else begin
                reject_bit = 1'b1;
              end
            end
          end
          A_ON: begin
            if (cnt_reg == ONE) begin
              if (d_reg != '0) begin
                state_next = DEAD1;
                cnt_next   = d_reg;
              end else begin
                state_next = B_ON;
                cnt_next   = b_reg;
              end
            end else begin
              cnt_next = cnt_reg - ONE;
            end
          end
          DEAD1: begin
            if (cnt_reg == ONE) begin
              state_next = B_ON;
              cnt_next   = b_reg;
            end else begin
              cnt_next = cnt_reg - ONE;
            end
          end
          B_ON: begin
            if (cnt_reg == ONE) begin
              if (d_reg != '0) begin
                state_next = DEAD2;
                cnt_next   = d_reg;
              end else begin
                period_end = 1'b1;
              end
            end else begin
              cnt_next = cnt_reg - ONE;
            end
          end
          DEAD2: begin
            if (cnt_reg == ONE) period_end = 1'b1;
            else                cnt_next   = cnt_reg - ONE;
          end
          default: state_next = IDLE;
        endcase

        // A stop seen on the final cycle of a period still ends the burst at that boundary.
        if (period_end) begin
          if (stop_reg || stop_mask[gi] || ((n_reg != '0) && (period_inc == n_reg))) begin
            state_next = IDLE;
            done_next  = 1'b1;
            stop_next  = 1'b0;
          end else begin
            state_next  = A_ON;
            cnt_next    = a_reg;
            period_next = period_inc;
          end
        end

        out_lvl = (state_next == IDLE) ? idle_level : lvl_next;
        pa_next = (state_next == A_ON) ? ~out_lvl : out_lvl;
        pb_next = (state_next == B_ON) ? ~out_lvl : out_lvl;
      end

      always_ff @(posedge io_clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg  <= IDLE;
          cnt_reg    <= '0;
          period_reg <= '0;
          a_reg      <= '0;
          b_reg      <= '0;
          d_reg      <= '0;
          n_reg      <= '0;
          lvl_reg    <= 1'b0;
          stop_reg   <= 1'b0;
          pa_reg     <= 1'b0;
          pb_reg     <= 1'b0;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b0;
        end else begin
          state_reg  <= state_next;
          cnt_reg    <= cnt_next;
          period_reg <= period_next;
          a_reg      <= a_next;
          b_reg      <= b_next;
          d_reg      <= d_next;
          n_reg      <= n_next;
          lvl_reg    <= lvl_next;
          stop_reg   <= stop_next;
          pa_reg     <= pa_next;
          pb_reg     <= pb_next;
          busy_reg   <= (state_next != IDLE);
          done_reg   <= done_next;
        end
      end

      assign pulse_a[gi] = pa_reg;
      assign pulse_b[gi] = pb_reg;
      assign busy[gi]    = busy_reg;
      assign done[gi]    = done_reg;
      assign reject[gi]  = reject_bit;
    end
  endgenerate

  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) cfg_err_reg <= 1'b0;
    else        cfg_err_reg <= |reject;
  end

  assign cfg_err = cfg_err_reg;

endmodule
